fifo_word_packer: RTL

//  Consumer stage directly downstream of the sync FIFO (syncfifo). Drains WIDTH-bit words via the

---
 rtl/fifo_word_packer_pkg.sv | 26 ++
 rtl/fifo_word_packer_if.sv | 35 +++
 rtl/fifo_word_packer_pack_idle_timer.sv | 38 +++
 rtl/fifo_word_packer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fifo_word_packer_pkg.sv
// memproj_pkg: shared definitions for the FIFO word packer.
//   pack_state_e  FSM state encoding (ST_FILL / ST_FULL)
//   DEF_WIDTH     default FIFO word width
//   DEF_RATIO     default words per packed beat
//   lane_mask()   mask with the low n bits set (lanes 0..n-1 valid)
package memproj_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } pack_state_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_RATIO = 4;

  // Returns 32 bits; callers truncate to their lane count (RATIO <= 32).
  function automatic logic [31:0] lane_mask(input int unsigned n);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// fifo_word_packer_if: FIFO read port plus packed valid/ready output stream.
//   fifo_empty  FIFO empty flag                      (FIFO -> packer)
//   fifo_rd_en  FIFO read request                    (packer -> FIFO)
//   fifo_rdata  FIFO read data, one cycle after rd   (FIFO -> packer)
//   out_valid   packed beat available                (packer -> sink)
//   out_ready   sink accepts beat                    (sink -> packer)
//   out_data    packed beat, first word in lane 0    (packer -> sink)
//   out_keep    per-lane valid mask                  (packer -> sink)
// Modports: master = packer side, slave = FIFO/sink side.
interface fifo_word_packer_if
  import memproj_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned RATIO = DEF_RATIO
);

  logic                   fifo_empty;
  logic                   fifo_rd_en;
  logic [WIDTH-1:0]       fifo_rdata;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH*RATIO-1:0] out_data;
  logic [RATIO-1:0]       out_keep;

  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_rd_en, out_valid, out_data, out_keep
  );

  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_keep
  );

endinterface

// File: rtl/fifo_word_packer_pack_idle_timer.sv
// pack_idle_timer: counts idle cycles of a partially filled beat and pulses
// flush on the TIMEOUT-th consecutive idle cycle. Any capture restarts the count.
//   clk, res  clock, async active-low reset
//   idle      packer is waiting on a partial beat with nothing in flight
//   capture   a FIFO word is being written into a lane this cycle
//   flush     combinational pulse: close the partial beat now
module pack_idle_timer
  import memproj_pkg::*;
#(
  parameter  int unsigned TIMEOUT = 64,
  localparam int unsigned IW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic res,
  input  logic idle,
  input  logic capture,
  output logic flush
);

  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  assign flush = idle && (idle_cnt_q == IW'(TIMEOUT - 1));

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (capture || flush) begin
      idle_cnt_d = '0;
    end else if (idle) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) idle_cnt_q <= '0;
    else      idle_cnt_q <= idle_cnt_d;
  end

endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains WIDTH-bit words from a sync FIFO (registered rdata,
// one-cycle read latency) and packs RATIO of them into one WIDTH*RATIO beat.
//   clk   clock, rising edge
//   res   asynchronous reset, active-low
//   bus   fifo_word_packer_if.master (FIFO read port + valid/ready output)
// Optional macro PACK_TIMEOUT_EN: flush a partial beat (out_keep marks filled
// lanes, unfilled lanes zero) after TIMEOUT idle cycles. Without it out_keep
// stays all ones and partial beats wait indefinitely.
module fifo_word_packer
  import memproj_pkg::*;
#(
  parameter  int unsigned WIDTH   = DEF_WIDTH,
  parameter  int unsigned RATIO   = DEF_RATIO,
  parameter  int unsigned TIMEOUT = 64,
  localparam int unsigned CNT_W   = $clog2(RATIO + 1)
) (
  input logic                clk,
  input logic                res,
  fifo_word_packer_if.master bus
);

  localparam logic [CNT_W:0] RATIO_R = (CNT_W + 1)'(RATIO);

  pack_state_e            state_q, state_d;
  logic [CNT_W-1:0]       lane_cnt_q, lane_cnt_d;
  logic                   rd_pend_q;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH*RATIO-1:0] out_data_q, out_data_d;
  logic [RATIO-1:0]       out_keep_q, out_keep_d;
  logic [CNT_W:0]         reserved;
  logic                   rd_en;

  // Lanes already filled plus the word still in flight from the FIFO.
  assign reserved = {1'b0, lane_cnt_q} + {{CNT_W{1'b0}}, rd_pend_q};

`ifdef PACK_TIMEOUT_EN
  logic idle;
  logic flush;

  assign idle = (state_q == ST_FILL) && (lane_cnt_q != '0) && !rd_pend_q && bus.fifo_empty;

  pack_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .res     (res),
    .idle    (idle),
    .capture (rd_pend_q),
    .flush   (flush)
  );
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    rd_en       = 1'b0;

    unique case (state_q)
      ST_FILL: rd_en = !bus.fifo_empty && (reserved < RATIO_R);
      // Prefetch only when the held beat leaves this cycle, so lane 0 is
      // written the cycle after the handshake and no stored lane is clobbered.
      ST_FULL: rd_en = !bus.fifo_empty && bus.out_ready;
      default: rd_en = 1'b0;
    endcase

    if (rd_pend_q) begin
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (lane_cnt_q == CNT_W'(i)) out_data_d[i*WIDTH +: WIDTH] = bus.fifo_rdata;
      end
      lane_cnt_d = lane_cnt_q + CNT_W'(1);
      if (lane_cnt_q == CNT_W'(RATIO - 1)) begin
        state_d     = ST_FULL;
        out_valid_d = 1'b1;
        out_keep_d  = '1;
      end
    end

`ifdef PACK_TIMEOUT_EN
    // Stale lanes from the previous beat are cleared so a partial beat never
    // leaks old data even in lanes the sink is told to ignore.
    if (flush) begin
      state_d     = ST_FULL;
      out_valid_d = 1'b1;
      out_keep_d  = RATIO'(lane_mask(32'(lane_cnt_q)));
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (CNT_W'(i) >= lane_cnt_q) out_data_d[i*WIDTH +: WIDTH] = '0;
      end
    end
`endif

    if ((state_q == ST_FULL) && bus.out_ready) begin
      state_d     = ST_FILL;
      lane_cnt_d  = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= ST_FILL;
      lane_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '1;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      rd_pend_q   <= rd_en;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_keep   = out_keep_q;

endmodule
